greg_mp: RTL and testbench
==========================

# greg_mp

Parametrised multi-port general register file for the MIPS core, successor to the single-write-port register file. It provides two combinational read ports and two posedge write ports with defined same-address priority, and optional write-to-read bypass for the decode stage. It also has a sequential context-clear engine that zeroes the array one entry per cycle. It sits between decode (read ports) and writeback/load-return (write ports).

## Interface
Parameters:
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, address width; depth `DEPTH = 2**ADDR_W`
- `ZERO_R0`, 1, when 1 entry 0 is hardwired to zero and writes to it are dropped

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `wr0_en`  in  1  write port 0 enable
- `wr0_addr`  in  ADDR_W  write port 0 address
- `wr0_data`  in  DATA_W  write port 0 data
- `wr1_en`  in  1  write port 1 enable; wins over port 0 on the same address
- `wr1_addr`  in  ADDR_W  write port 1 address
- `wr1_data`  in  DATA_W  write port 1 data
- `rd0_addr`, `rd1_addr`  in  ADDR_W  read addresses
- `rd0_data`, `rd1_data`  out  DATA_W  read data, combinational
- `clr_req`  in  1  one-cycle request to start a context clear
- `clr_busy`  out  1  high while the clear engine runs
- `wr_conflict`  out  1  registered one-cycle flag for a same-address dual write

## Operation
- Reads are combinational from the array.
  - With `ZERO_R0`=1, address 0 always reads 0.
- Writes commit on the rising edge when enabled, not blocked, and not (`ZERO_R0` and address 0).
- Both ports enabled on the same address:
  - port 1 data is stored and port 0 is discarded;
  - `wr_conflict` rises the next cycle for exactly one cycle. It is not raised for address 0 when `ZERO_R0`=1.
- Clear FSM has two states, IDLE and CLEAR, with a pointer `ptr` of ADDR_W bits.
  - IDLE, `clr_req`=1: go to CLEAR, `ptr`<=0.
  - CLEAR: each cycle `mem[ptr]`<=0 and `ptr`<=`ptr`+1. When `ptr`==DEPTH-1, that entry is cleared and the FSM returns to IDLE. `ptr` wraps to 0.
  - In CLEAR, both write ports are ignored and `wr_conflict` is not raised.
  - In CLEAR, reads return current array contents.
  - `clr_req` in CLEAR is ignored; there is no restart.
- Reset (`rst_n`=0 at an edge): every entry zeroed in that cycle, FSM to IDLE, `ptr`<=0, `wr_conflict`<=0. This applies during CLEAR as well and aborts it.

## Timing
- Reset values: `clr_busy`=0, `wr_conflict`=0, all entries 0, so `rd*_data`=0.
- Write latency: data written at edge N is visible on read ports after edge N. With bypass enabled it is visible combinationally in the cycle before edge N.
- `clr_busy` is high from the cycle after the `clr_req` edge for exactly DEPTH cycles.
- Writes presented on the `clr_req` edge itself, while still in IDLE, are committed before the clear begins.
- `wr_conflict` is registered and asserted in cycle N+1 for a conflict at edge N.
- No back-pressure on write ports. Callers must not issue writes while `clr_busy`=1; such writes are silently lost.

## Configuration
- `GREG_BYPASS_EN` defined: each read port compares against both write ports.
  - On an address match with a committing write (enabled, `clr_busy`=0, not the zero register), `rd*_data` returns the write data combinationally.
  - Port 1 wins over port 0 when both match.
- `GREG_BYPASS_EN` undefined: read ports return only stored array contents.
  - Same-cycle write data is not visible until after the edge.
  - No comparators are synthesised.

## Test plan
- Reset then read: hold `rst_n`=0 one edge after writing 0xDEADBEEF to r5. Expect `rd0_addr`=5 to read 0, and `clr_busy`=0, `wr_conflict`=0.
- Dual write: write r7 with port0=0x11111111 and port1=0x22222222 on the same edge. Expect r7 to read 0x22222222 and `wr_conflict`=1 for exactly one cycle.
- Zero register: with `ZERO_R0`=1, write 0x12345678 to r0 on both ports. Expect r0 to read 0 and `wr_conflict`=0.
- Bypass: write r3=0xCAFEF00D with `rd1_addr`=3 in the same cycle. With `GREG_BYPASS_EN`, expect 0xCAFEF00D before the edge; without it, expect the old value 0 before the edge and 0xCAFEF00D after.
- Context clear: fill r1..r31 with the value i, then pulse `clr_req`. Expect `clr_busy` high for 32 cycles, every entry reading 0 afterwards, and a write issued mid-clear to be dropped.
- Reset mid-clear: pulse `clr_req`, then drop `rst_n` for one edge 10 cycles later. Expect `clr_busy`=0 the next cycle and all entries 0, including entries beyond `ptr`.

Source files
------------

// File: rtl/greg_mp.sv
`default_nettype none
// ============================================================================
// Module   : greg_mp
// Brief    : Two-read / two-write general register file with a sequential
//            context-clear engine. Optional bypass: GREG_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module greg_mp #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int ZERO_R0 = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr0_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic [ADDR_W-1:0] rd0_addr,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd0_data,
  output logic [DATA_W-1:0] rd1_data,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              wr_conflict
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_wr_conflict;

  logic w_busy;
  logic w_wr0_ok;
  logic w_wr1_ok;
  logic w_conflict;

  assign w_busy   = (r_state == S_CLEAR);
  // A write "commits" only when enabled, outside a clear, and not aimed at a hardwired r0.
  assign w_wr0_ok = wr0_en && !w_busy && !((ZERO_R0 != 0) && (wr0_addr == '0));
  assign w_wr1_ok = wr1_en && !w_busy && !((ZERO_R0 != 0) && (wr1_addr == '0));
  assign w_conflict = w_wr0_ok && w_wr1_ok && (wr0_addr == wr1_addr);

  assign clr_busy    = w_busy;
  assign wr_conflict = r_wr_conflict;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (clr_req) begin
          w_state_nxt = S_CLEAR;
          w_ptr_nxt   = '0;
        end
      end
      S_CLEAR: begin
        w_ptr_nxt = r_ptr + ADDR_W'(1);
        if (r_ptr == ADDR_W'(DEPTH - 1)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  // Port 1 is assigned last so it overrides port 0 on a shared address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_busy) begin
      r_mem[r_ptr] <= '0;
    end else begin
      if (w_wr0_ok) r_mem[wr0_addr] <= wr0_data;
      if (w_wr1_ok) r_mem[wr1_addr] <= wr1_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_conflict <= 1'b0;
    end else begin
      r_wr_conflict <= w_conflict;
    end
  end

  function automatic logic [DATA_W-1:0] f_read(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] v;
    v = ((ZERO_R0 != 0) && (addr == '0)) ? '0 : r_mem[addr];
`ifdef GREG_BYPASS_EN
    if (w_wr1_ok && (wr1_addr == addr)) begin
      v = wr1_data;
    end else if (w_wr0_ok && (wr0_addr == addr)) begin
      v = wr0_data;
    end
`endif
    return v;
  endfunction

  always_comb begin
    rd0_data = f_read(rd0_addr);
  end

  always_comb begin
    rd1_data = f_read(rd1_addr);
  end

endmodule
`default_nettype wire

// File: tb/tb_greg_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_greg_mp
// Brief    : Directed self-checking bench for greg_mp (honours GREG_BYPASS_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_greg_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr0_en, wr1_en;
  logic [ADDR_W-1:0] wr0_addr, wr1_addr;
  logic [DATA_W-1:0] wr0_data, wr1_data;
  logic [ADDR_W-1:0] rd0_addr, rd1_addr;
  logic [DATA_W-1:0] rd0_data, rd1_data;
  logic              clr_req;
  logic              clr_busy;
  logic              wr_conflict;

  int n_cmp = 0;
  int n_bad = 0;

  greg_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_R0(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr0_en     (wr0_en),
    .wr0_addr   (wr0_addr),
    .wr0_data   (wr0_data),
    .wr1_en     (wr1_en),
    .wr1_addr   (wr1_addr),
    .wr1_data   (wr1_data),
    .rd0_addr   (rd0_addr),
    .rd1_addr   (rd1_addr),
    .rd0_data   (rd0_data),
    .rd1_data   (rd1_data),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy),
    .wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
    clr_req = 1'b0;
  endtask

  task automatic fill(input logic [DATA_W-1:0] base);
    for (int i = 1; i < DEPTH; i++) begin
      wr0_en = 1'b1; wr0_addr = ADDR_W'(i); wr0_data = base + DATA_W'(i);
      tick();
    end
    wr0_en = 1'b0;
  endtask

  task automatic test_reset();
    // Power-on reset
    rst_n = 1'b0; idle_inputs(); rd0_addr = '0; rd1_addr = '0;
    tick(); tick();
    rst_n = 1'b1;
    n_cmp++;
    if (clr_busy !== 1'b0) begin n_bad++; $display("FAIL por_clr_busy: got %b expected 0", clr_busy); end
    n_cmp++;
    if (wr_conflict !== 1'b0) begin n_bad++; $display("FAIL por_wr_conflict: got %b expected 0", wr_conflict); end
    // Write r5 then reset one edge
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF; rd0_addr = 5'd5;
    tick();
    wr0_en = 1'b0;
    n_cmp++;
    if (rd0_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL pre_reset_r5: got %h expected deadbeef", rd0_data); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if (rd0_data !== 32'h0) begin n_bad++; $display("FAIL reset_r5: got %h expected 00000000", rd0_data); end
    n_cmp++;
    if (clr_busy !== 1'b0) begin n_bad++; $display("FAIL reset_clr_busy: got %b expected 0", clr_busy); end
    n_cmp++;
    if (wr_conflict !== 1'b0) begin n_bad++; $display("FAIL reset_wr_conflict: got %b expected 0", wr_conflict); end
  endtask

  task automatic test_single_writes();
    wr0_en = 1'b1; wr0_addr = 5'd1; wr0_data = 32'hA5A5_0001;
    wr1_en = 1'b1; wr1_addr = 5'd2; wr1_data = 32'h5A5A_0002;
    rd0_addr = 5'd1; rd1_addr = 5'd2;
    tick();
    idle_inputs();
    n_cmp++;
    if (rd0_data !== 32'hA5A5_0001) begin n_bad++; $display("FAIL port0_write: got %h expected a5a50001", rd0_data); end
    n_cmp++;
    if (rd1_data !== 32'h5A5A_0002) begin n_bad++; $display("FAIL port1_write: got %h expected 5a5a0002", rd1_data); end
    n_cmp++;
    if (wr_conflict !== 1'b0) begin n_bad++; $display("FAIL distinct_no_conflict: got %b expected 0", wr_conflict); end
  endtask

  task automatic test_dual_write();
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h11111111;
    wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h22222222;
    rd0_addr = 5'd7;
    tick();
    idle_inputs();
    n_cmp++;
    if (rd0_data !== 32'h22222222) begin n_bad++; $display("FAIL dual_write_data: got %h expected 22222222", rd0_data); end
    n_cmp++;
    if (wr_conflict !== 1'b1) begin n_bad++; $display("FAIL dual_conflict_set: got %b expected 1", wr_conflict); end
    tick();
    n_cmp++;
    if (wr_conflict !== 1'b0) begin n_bad++; $display("FAIL dual_conflict_one_cycle: got %b expected 0", wr_conflict); end
  endtask

  task automatic test_zero_reg();
    wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'h12345678;
    wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 32'h12345678;
    rd0_addr = 5'd0;
    #1;
    n_cmp++;
    if (rd0_data !== 32'h0) begin n_bad++; $display("FAIL r0_before_edge: got %h expected 00000000", rd0_data); end
    tick();
    idle_inputs();
    n_cmp++;
    if (rd0_data !== 32'h0) begin n_bad++; $display("FAIL r0_read: got %h expected 00000000", rd0_data); end
    n_cmp++;
    if (wr_conflict !== 1'b0) begin n_bad++; $display("FAIL r0_no_conflict: got %b expected 0", wr_conflict); end
  endtask

  task automatic test_bypass();
    logic [DATA_W-1:0] exp_pre;
    wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'hCAFEF00D;
    rd1_addr = 5'd3;
    #1;
`ifdef GREG_BYPASS_EN
    exp_pre = 32'hCAFEF00D;
`else
    exp_pre = 32'h0;
`endif
    n_cmp++;
    if (rd1_data !== exp_pre) begin n_bad++; $display("FAIL bypass_pre_edge: got %h expected %h", rd1_data, exp_pre); end
    tick();
    idle_inputs();
    n_cmp++;
    if (rd1_data !== 32'hCAFEF00D) begin n_bad++; $display("FAIL bypass_post_edge: got %h expected cafef00d", rd1_data); end
    // Both ports target r4: port 1 must be the one seen
    wr0_en = 1'b1; wr0_addr = 5'd4; wr0_data = 32'h0000_AAAA;
    wr1_en = 1'b1; wr1_addr = 5'd4; wr1_data = 32'h0000_BBBB;
    rd0_addr = 5'd4;
    #1;
`ifdef GREG_BYPASS_EN
    exp_pre = 32'h0000_BBBB;
`else
    exp_pre = 32'h0;
`endif
    n_cmp++;
    if (rd0_data !== exp_pre) begin n_bad++; $display("FAIL bypass_priority: got %h expected %h", rd0_data, exp_pre); end
    tick();
    idle_inputs();
  endtask

  task automatic test_context_clear();
    int busy_cnt;
    fill(32'h0);
    rd0_addr = 5'd31;
    #1;
    n_cmp++;
    if (rd0_data !== 32'd31) begin n_bad++; $display("FAIL fill_r31: got %h expected 0000001f", rd0_data); end
    // Write on the request edge lands before the clear starts
    clr_req = 1'b1;
    wr1_en = 1'b1; wr1_addr = 5'd30; wr1_data = 32'h0000_0055;
    rd0_addr = 5'd20; rd1_addr = 5'd30;
    tick();
    idle_inputs();
    busy_cnt = 0;
    while (clr_busy === 1'b1 && busy_cnt < 100) begin
      if (busy_cnt == 0) begin
        n_cmp++;
        if (rd0_data !== 32'd20) begin n_bad++; $display("FAIL clear_read_live: got %h expected 00000014", rd0_data); end
        n_cmp++;
        if (rd1_data !== 32'h55) begin n_bad++; $display("FAIL req_edge_write: got %h expected 00000055", rd1_data); end
      end
      idle_inputs();
      if (busy_cnt == 10) begin
        wr0_en = 1'b1; wr0_addr = 5'd2; wr0_data = 32'h0000_0BAD;
        wr1_en = 1'b1; wr1_addr = 5'd2; wr1_data = 32'h0000_0BAD;
      end
      if (busy_cnt == 11) begin
        n_cmp++;
        if (wr_conflict !== 1'b0) begin n_bad++; $display("FAIL clear_no_conflict: got %b expected 0", wr_conflict); end
      end
      if (busy_cnt == 15) clr_req = 1'b1;
      tick();
      busy_cnt++;
    end
    idle_inputs();
    n_cmp++;
    if (busy_cnt !== DEPTH) begin n_bad++; $display("FAIL clear_busy_cycles: got %0d expected %0d", busy_cnt, DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      rd0_addr = ADDR_W'(i);
      #1;
      n_cmp++;
      if (rd0_data !== 32'h0) begin n_bad++; $display("FAIL clear_entry_%0d: got %h expected 00000000", i, rd0_data); end
    end
  endtask

  task automatic test_reset_mid_clear();
    fill(32'h100);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    n_cmp++;
    if (clr_busy !== 1'b1) begin n_bad++; $display("FAIL mid_clear_busy: got %b expected 1", clr_busy); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if (clr_busy !== 1'b0) begin n_bad++; $display("FAIL abort_clr_busy: got %b expected 0", clr_busy); end
    for (int i = 0; i < DEPTH; i++) begin
      rd1_addr = ADDR_W'(i);
      #1;
      n_cmp++;
      if (rd1_data !== 32'h0) begin n_bad++; $display("FAIL abort_entry_%0d: got %h expected 00000000", i, rd1_data); end
    end
    // The engine must stay idle after the abort
    tick();
    n_cmp++;
    if (clr_busy !== 1'b0) begin n_bad++; $display("FAIL abort_stays_idle: got %b expected 0", clr_busy); end
  endtask

  initial begin
    test_reset();
    test_single_writes();
    test_dual_write();
    test_zero_reg();
    test_bypass();
    test_context_clear();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
